// File: rtl/register_file_write.sv
// register_file_write
//
// Write side of the MIPS multi-cycle register file together with its two
// combinational read ports. A 5-to-32 one-hot decoder turns the destination
// index into per-register write enables. The enables are gated by regWrite
// and clock writeData into one of registers 1..31. Register 0 has no storage
// and always reads as zero.
//
// Ports:
//   clk        rising-edge clock for all register writes
//   reset      asynchronous, active-high; clears registers 1..31
//   regWrite   write enable from the control FSM
//   writeReg   destination register index (rd or rt)
//   writeData  value to write (ALUOut or MDR)
//   readReg1   rs index for read port 1
//   readReg2   rt index for read port 2
//   readData1  contents of register readReg1 (zero for index 0)
//   readData2  contents of register readReg2 (zero for index 0)

module register_file_write (
  input  logic        clk,
  input  logic        reset,
  input  logic        regWrite,
  input  logic [4:0]  writeReg,
  input  logic [31:0] writeData,
  input  logic [4:0]  readReg1,
  input  logic [4:0]  readReg2,
  output logic [31:0] readData1,
  output logic [31:0] readData2
);

  logic [31:0] dec;
  logic [31:0] we;

  // Only registers 1..31 hold state; index 0 is synthesised as a constant.
  logic [31:0] regs [1:31];

  // Read view covering all 32 indices, so the read muxes need no special case.
  logic [31:0] reg_view [0:31];

  // One-hot decode of the destination index.
  always_comb begin
    dec = '0;
    for (int i = 0; i < 32; i++) begin
      dec[i] = (writeReg == 5'(i));
    end
  end

  // Bit 0 is forced low so a write to register 0 has no side effect.
  always_comb begin
    we    = dec & {32{regWrite}};
    we[0] = 1'b0;
  end

  // Reset overrides any write on the same edge, so a coincident write is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (we[i]) begin
          regs[i] <= writeData;
        end
      end
    end
  end

  always_comb begin
    reg_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      reg_view[i] = regs[i];
    end
  end

  // The read ports have no bypass. A read of the register being written
  // shows the old value until the edge.
  assign readData1 = reg_view[readReg1];
  assign readData2 = reg_view[readReg2];

endmodule

// File: tb/tb_register_file_write.sv
// tb_register_file_write
//
// Self-checking bench for register_file_write. Expected read values are
// pushed onto a scoreboard queue when the stimulus is driven. They are popped
// and compared when the read ports are sampled. A small shadow array holds the
// register contents the bench expects.
//
// Ports of the DUT are all driven/observed from this module; no ports here.

module tb_register_file_write;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int          pass_count;
  int          check_count;
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  logic [31:0] model [0:31];

  register_file_write dut (
    .clk       (clk),
    .reset     (reset),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2)
  );

  // 10-unit clock period; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one write at the falling edge, let the next rising edge take it,
  // then drop regWrite again. The shadow model is updated to match.
  task automatic applyStimulus(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    regWrite  = 1'b1;
    writeReg  = idx;
    writeData = data;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    if (idx != 5'd0) model[idx] = data;
  endtask

  task automatic test_reset();
    // Power-on reset: every index reads zero on both ports.
    for (int i = 0; i < 32; i += 8) begin
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      readReg1 = 5'(i);
      readReg2 = 5'(i + 7);
      #1;
      exp_v = exp_q.pop_front();
      check_count++;
      if (readData1 !== exp_v) $display("[TB] FAIL por_rd1 idx=%0d got=%h exp=%h", i, readData1, exp_v);
      else pass_count++;
      exp_v = exp_q.pop_front();
      check_count++;
      if (readData2 !== exp_v) $display("[TB] FAIL por_rd2 idx=%0d got=%h exp=%h", i + 7, readData2, exp_v);
      else pass_count++;
    end
    @(negedge clk);
    reset = 1'b0;

    // Mid-run reset clears a loaded register before the next clock edge.
    applyStimulus(5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    readReg1 = 5'd5;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData1 !== exp_v) $display("[TB] FAIL pre_reset_r5 got=%h exp=%h", readData1, exp_v);
    else pass_count++;

    reset = 1'b1;
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData1 !== exp_v) $display("[TB] FAIL async_reset_r5 got=%h exp=%h", readData1, exp_v);
    else pass_count++;

    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      readReg1 = 5'(i);
      readReg2 = 5'(31 - i);
      #1;
      exp_v = exp_q.pop_front();
      check_count++;
      if (readData1 !== exp_v) $display("[TB] FAIL reset_all_rd1 idx=%0d got=%h exp=%h", i, readData1, exp_v);
      else pass_count++;
      exp_v = exp_q.pop_front();
      check_count++;
      if (readData2 !== exp_v) $display("[TB] FAIL reset_all_rd2 idx=%0d got=%h exp=%h", 31 - i, readData2, exp_v);
      else pass_count++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_write();
    applyStimulus(5'd8, 32'h1234_5678);
    readReg1 = 5'd8;
    readReg2 = 5'd9;
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData1 !== exp_v) $display("[TB] FAIL basic_r8 got=%h exp=%h", readData1, exp_v);
    else pass_count++;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData2 !== exp_v) $display("[TB] FAIL basic_r9 got=%h exp=%h", readData2, exp_v);
    else pass_count++;
  endtask

  task automatic test_reg_zero();
    applyStimulus(5'd7, 32'h0BAD_F00D);
    applyStimulus(5'd0, 32'hFFFF_FFFF);
    readReg1 = 5'd0;
    readReg2 = 5'd0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData1 !== exp_v) $display("[TB] FAIL r0_rd1 got=%h exp=%h", readData1, exp_v);
    else pass_count++;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData2 !== exp_v) $display("[TB] FAIL r0_rd2 got=%h exp=%h", readData2, exp_v);
    else pass_count++;

    // No other register picked up the discarded write.
    for (int i = 1; i < 32; i++) begin
      exp_q.push_back(model[i]);
      readReg1 = 5'(i);
      #1;
      exp_v = exp_q.pop_front();
      check_count++;
      if (readData1 !== exp_v) $display("[TB] FAIL r0_side_effect idx=%0d got=%h exp=%h", i, readData1, exp_v);
      else pass_count++;
    end
  endtask

  task automatic test_write_disabled();
    applyStimulus(5'd3, 32'hA5A5_A5A5);
    @(negedge clk);
    regWrite  = 1'b0;
    writeReg  = 5'd3;
    writeData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    readReg2 = 5'd3;
    exp_q.push_back(32'hA5A5_A5A5);
    #1;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData2 !== exp_v) $display("[TB] FAIL wr_disabled_r3 got=%h exp=%h", readData2, exp_v);
    else pass_count++;
  endtask

  task automatic test_read_during_write();
    applyStimulus(5'd10, 32'h1);
    @(negedge clk);
    readReg1  = 5'd10;
    readReg2  = 5'd10;
    regWrite  = 1'b1;
    writeReg  = 5'd10;
    writeData = 32'h2;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    #1;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData1 !== exp_v) $display("[TB] FAIL rdw_before_rd1 got=%h exp=%h", readData1, exp_v);
    else pass_count++;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData2 !== exp_v) $display("[TB] FAIL rdw_before_rd2 got=%h exp=%h", readData2, exp_v);
    else pass_count++;

    exp_q.push_back(32'h2);
    exp_q.push_back(32'h2);
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    model[10] = 32'h2;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData1 !== exp_v) $display("[TB] FAIL rdw_after_rd1 got=%h exp=%h", readData1, exp_v);
    else pass_count++;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData2 !== exp_v) $display("[TB] FAIL rdw_after_rd2 got=%h exp=%h", readData2, exp_v);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h0000_0011;
    vals[1] = 32'h0000_0022;
    vals[2] = 32'h0000_0033;
    readReg1 = 5'd12;
    @(negedge clk);
    regWrite = 1'b1;
    writeReg = 5'd12;
    for (int k = 0; k < 3; k++) begin
      writeData = vals[k];
      exp_q.push_back(vals[k]);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      check_count++;
      if (readData1 !== exp_v) $display("[TB] FAIL b2b_r12 step=%0d got=%h exp=%h", k, readData1, exp_v);
      else pass_count++;
    end
    regWrite = 1'b0;
    model[12] = vals[2];
  endtask

  task automatic test_decoder_sweep();
    for (int i = 1; i < 32; i++) begin
      applyStimulus(5'(i), (32'(i) << 16) | 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back((i == 0) ? 32'h0 : ((32'(i) << 16) | 32'(i)));
      exp_q.push_back((i == 0) ? 32'h0 : ((32'(i) << 16) | 32'(i)));
      readReg1 = 5'(i);
      readReg2 = 5'(i);
      #1;
      exp_v = exp_q.pop_front();
      check_count++;
      if (readData1 !== exp_v) $display("[TB] FAIL sweep_rd1 idx=%0d got=%h exp=%h", i, readData1, exp_v);
      else pass_count++;
      exp_v = exp_q.pop_front();
      check_count++;
      if (readData2 !== exp_v) $display("[TB] FAIL sweep_rd2 idx=%0d got=%h exp=%h", i, readData2, exp_v);
      else pass_count++;
    end

    // Reset coincident with a write to register 31: the write is lost.
    @(negedge clk);
    regWrite  = 1'b1;
    writeReg  = 5'd31;
    writeData = 32'hFFFF_FFFF;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    readReg1 = 5'd31;
    readReg2 = 5'd30;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData1 !== exp_v) $display("[TB] FAIL reset_vs_write_r31 got=%h exp=%h", readData1, exp_v);
    else pass_count++;
    exp_v = exp_q.pop_front();
    check_count++;
    if (readData2 !== exp_v) $display("[TB] FAIL reset_vs_write_r30 got=%h exp=%h", readData2, exp_v);
    else pass_count++;
  endtask

  initial begin
    pass_count  = 0;
    check_count = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset     = 1'b1;
    regWrite  = 1'b0;
    writeReg  = 5'd0;
    writeData = 32'h0;
    readReg1  = 5'd0;
    readReg2  = 5'd0;

    test_reset();
    test_basic_write();
    test_reg_zero();
    test_write_disabled();
    test_read_during_write();
    test_back_to_back();
    test_decoder_sweep();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
